imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_asm.sv | 64 ++++++
 rtl/imem_loader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state encoding, frame byte order and default geometry.
package imem_loader_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DEPTH  = 512;

  // Payload words arrive most-significant byte first.
  localparam bit FRAME_MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHK    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

endpackage

// File: rtl/imem_loader_asm.sv
// Byte-to-word assembler: 2-bit byte index, 32-bit shift register,
// running XOR of frame bytes and a one-cycle word_done pulse that is
// raised the cycle after the 4th byte of a word is accepted.
module imem_loader_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,        // restart of a new frame
  input  logic        data_en,    // payload byte accepted this cycle
  input  logic        xor_en,     // byte contributes to the checksum
  input  logic [7:0]  din,
  output logic        last_byte,  // next payload byte completes a word
  output logic        word_done,
  output logic [31:0] word,
  output logic [7:0]  xsum
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] shreg_q, shreg_d;
  logic [7:0]  xor_q, xor_d;
  logic        word_done_q, word_done_d;

  assign last_byte = (idx_q == 2'd3);
  assign word_done = word_done_q;
  assign word      = shreg_q;
  assign xsum      = xor_q;

  // Shift in payload bytes, fold accepted bytes into the checksum.
  always_comb begin
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    xor_d       = xor_q;
    word_done_d = 1'b0;
    if (clr) begin
      idx_d   = '0;
      shreg_d = '0;
      xor_d   = '0;
    end else begin
      if (xor_en) xor_d = xor_q ^ din;
      if (data_en) begin
        shreg_d     = FRAME_MSB_FIRST ? {shreg_q[23:0], din} : {din, shreg_q[31:8]};
        idx_d       = idx_q + 2'd1;
        word_done_d = last_byte;
      end
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      shreg_q     <= '0;
      xor_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      xor_q       <= xor_d;
      word_done_q <= word_done_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a framed byte stream (count, payload,
// XOR checksum), writes words to instruction memory and releases the
// core reset only after a frame with a good checksum.
// Optional inter-byte timeout: define IMEM_LOADER_TIMEOUT_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_wren,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  if (DEPTH > (1 << ADDR_W) || DEPTH < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("imem_loader: illegal DEPTH/ADDR_W/TIMEOUT_CYC");
  end

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d, err_q, err_d, cpu_rst_n_q, cpu_rst_n_d;
  logic              accept, clr, data_en, xor_en, last_byte, word_done, tmo_hit;
  logic              last_word;
  logic [15:0]       cnt_full;
  logic [31:0]       word;
  logic [7:0]        xsum;

  assign rx_ready  = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                     (state_q == ST_DATA)   || (state_q == ST_CHK);
  assign accept    = rx_valid && rx_ready;
  assign cnt_full  = {cnt_q[15:8], rx_data};
  // addr_q already points at the word being assembled when its 4th byte arrives.
  assign last_word = (32'(addr_q) == 32'(cnt_q) - 32'd1);
  assign data_en   = accept && (state_q == ST_DATA);
  assign xor_en    = accept && (state_q != ST_CHK);

  imem_loader_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .data_en   (data_en),
    .xor_en    (xor_en),
    .din       (rx_data),
    .last_byte (last_byte),
    .word_done (word_done),
    .word      (word),
    .xsum      (xsum)
  );

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Count idle cycles between bytes; HDR_HI waits for the host forever.
  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (accept || !rx_ready || state_q == ST_HDR_HI) begin
      tmo_d = '0;
    end else begin
      tmo_d   = tmo_q + TMO_W'(1);
      tmo_hit = (32'(tmo_d) >= TIMEOUT_CYC);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Frame-parsing FSM: next state, count latch and restart control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    case (state_q)
      ST_HDR_HI: if (accept) begin
        cnt_d[15:8] = rx_data;
        state_d     = ST_HDR_LO;
      end
      ST_HDR_LO: if (accept) begin
        cnt_d = cnt_full;
        if (32'(cnt_full) > 32'(DEPTH)) state_d = ST_ERR;
        else if (cnt_full == 16'd0)     state_d = ST_CHK;
        else                            state_d = ST_DATA;
      end
      ST_DATA: if (accept && last_byte && last_word) state_d = ST_CHK;
      ST_CHK: if (accept) state_d = (rx_data == xsum) ? ST_DONE : ST_ERR;
      ST_DONE, ST_ERR: if (reload) begin
        state_d = ST_HDR_HI;
        cnt_d   = '0;
        clr     = 1'b1;
      end
      default: state_d = ST_HDR_HI;
    endcase
    if (tmo_hit) state_d = ST_ERR;
  end

  // Word address advances after each write; status flags follow next state.
  always_comb begin
    addr_d      = addr_q;
    if (clr)            addr_d = '0;
    else if (imem_wren) addr_d = addr_q + ADDR_W'(1);
    done_d      = (state_d == ST_DONE);
    cpu_rst_n_d = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);
  end

  // Loader state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HDR_HI;
      cnt_q       <= '0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign imem_wren  = word_done && (state_q != ST_ERR);
  assign imem_addr  = addr_q;
  assign imem_wdata = word;
  assign done       = done_q;
  assign err        = err_q;
  assign cpu_rst_n  = cpu_rst_n_q;

endmodule
